wb_slave_splitter: RTL and testbench

//  Fans the Caravel MGMT SoC Wishbone slave port out to N_SLAVES user sub-blocks in user_project_wrapper.

---
 rtl/wb_slave_splitter.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_slave_splitter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_splitter.sv
// ---------------------------------------------------------------------------
// wb_slave_splitter
//
// Purpose:
//   Splits the Caravel management SoC Wishbone slave port across N_SLAVES
//   user sub-blocks. Each sub-block owns a fixed 2**SLAVE_ADDR_BITS-byte
//   window starting at ADDR_BASE. The request is registered on accept and
//   the read data is registered on the slave ack, so only one transaction is
//   ever outstanding. Out-of-range accesses (and, when enabled, slaves that
//   never answer) complete with ERR_DATA so the SoC cannot hang.
//
// Optional feature macro:
//   WB_SPLITTER_TIMEOUT_EN - when defined, a 16-bit watchdog terminates an
//                            ACTIVE transaction after TIMEOUT_CYCLES cycles
//                            without a slave ack.
//
// Ports:
//   wb_clk_i   in   1                 single clock
//   wb_rst_i   in   1                 synchronous, active-high reset
//   wbs_cyc_i  in   1                 upstream cycle
//   wbs_stb_i  in   1                 upstream strobe
//   wbs_we_i   in   1                 upstream write enable
//   wbs_sel_i  in   4                 upstream byte selects
//   wbs_adr_i  in   32                upstream byte address
//   wbs_dat_i  in   32                upstream write data
//   wbs_ack_o  out  1                 one-cycle ack to upstream
//   wbs_dat_o  out  32                read data, zero unless wbs_ack_o=1
//   m_cyc_o    out  N_SLAVES          per-slave cycle, one-hot or zero
//   m_stb_o    out  N_SLAVES          per-slave strobe, equal to m_cyc_o
//   m_we_o     out  1                 registered write enable
//   m_sel_o    out  4                 registered byte selects
//   m_adr_o    out  SLAVE_ADDR_BITS   window-relative byte address
//   m_dat_o    out  32                registered write data
//   m_dat_i    in   N_SLAVES*32       slave read data, slave k at [32k +: 32]
//   m_ack_i    in   N_SLAVES          slave acks
//   err_irq_o  out  1                 one-cycle pulse on each error termination
//   err_cnt_o  out  8                 saturating error count
// ---------------------------------------------------------------------------
module wb_slave_splitter #(
    parameter int          N_SLAVES        = 4,
    parameter logic [31:0] ADDR_BASE       = 32'h3000_0000,
    parameter int          SLAVE_ADDR_BITS = 16,
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] ERR_DATA        = 32'hDEAD_C0DE
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [31:0]                wbs_dat_i,
    output logic                       wbs_ack_o,
    output logic [31:0]                wbs_dat_o,
    output logic [N_SLAVES-1:0]        m_cyc_o,
    output logic [N_SLAVES-1:0]        m_stb_o,
    output logic                       m_we_o,
    output logic [3:0]                 m_sel_o,
    output logic [SLAVE_ADDR_BITS-1:0] m_adr_o,
    output logic [31:0]                m_dat_o,
    input  logic [N_SLAVES*32-1:0]     m_dat_i,
    input  logic [N_SLAVES-1:0]        m_ack_i,
    output logic                       err_irq_o,
    output logic [7:0]                 err_cnt_o
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    // Window bounds are compared in 33 bits so a window ending exactly at
    // 2**32 does not wrap around to zero.
    localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(N_SLAVES) << SLAVE_ADDR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                       we_q;
    logic [3:0]                 sel_q;
    logic [31:0]                dat_q;
    logic [SLAVE_ADDR_BITS-1:0] adr_q;
    logic [IDX_W-1:0]           idx_q;
    logic [31:0]                rdata_q;
    logic [7:0]                 err_cnt_q;

    logic [31:0]                offset;
    logic                       in_range;
    logic [IDX_W-1:0]           idx_next;
    logic [N_SLAVES-1:0]        sel_onehot;
    logic                       sel_ack;
    logic [31:0]                sel_rdata;
    logic                       accept;
    logic                       slave_done;

`ifdef WB_SPLITTER_TIMEOUT_EN
    logic [15:0]                timer_q;
    logic                       timeout_hit;
`endif

    // Address decode of the live upstream request; only used on the accept
    // edge, after which the registered copy drives everything.
    always_comb begin
        offset   = wbs_adr_i - ADDR_BASE;
        in_range = ({1'b0, wbs_adr_i} >= WIN_LO) && ({1'b0, wbs_adr_i} < WIN_HI);
        idx_next = IDX_W'(offset >> SLAVE_ADDR_BITS);
    end

    // Selects the addressed slave's ack and read data using the registered
    // index; acks from every other slave are ignored.
    always_comb begin
        sel_onehot = '0;
        sel_ack    = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_ack       = m_ack_i[k];
                sel_rdata     = m_dat_i[32*k +: 32];
            end
        end
    end

`ifdef WB_SPLITTER_TIMEOUT_EN
    // Watchdog: held at zero outside ACTIVE so it starts from zero on entry,
    // and counts every ACTIVE cycle in which the slave has not acked.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != ST_ACTIVE) begin
            timer_q <= '0;
        end else if (!sel_ack) begin
            timer_q <= timer_q + 16'd1;
        end
    end

    // Fires in the last allowed ACTIVE cycle so the strobe is held for
    // exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        timeout_hit = (state_q == ST_ACTIVE) && !sel_ack
                      && (timer_q == 16'(TIMEOUT_CYCLES - 1));
    end
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In ACTIVE an upstream abort outranks a slave ack in
    // the same cycle, and a slave ack outranks the watchdog.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        slave_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
                    accept  = 1'b1;
                    state_d = in_range ? ST_ACTIVE : ST_ERR;
                end
            end
            ST_ACTIVE: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    slave_done = 1'b1;
                    state_d    = ST_RESP;
                end
`ifdef WB_SPLITTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture on accept and read-data capture on slave ack. Writes
    // capture zero so the upstream ack carries no stale data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q  <= wbs_we_i;
                sel_q <= wbs_sel_i;
                dat_q <= wbs_dat_i;
                adr_q <= offset[SLAVE_ADDR_BITS-1:0];
                idx_q <= idx_next;
            end
            if (slave_done) begin
                rdata_q <= we_q ? 32'h0 : sel_rdata;
            end
        end
    end

    // Error counter advances once per error-ack cycle and sticks at 8'hFF.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            err_cnt_q <= '0;
        end else if (state_q == ST_ERR && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign m_cyc_o   = (state_q == ST_ACTIVE) ? sel_onehot : '0;
    assign m_stb_o   = m_cyc_o;
    assign m_we_o    = we_q;
    assign m_sel_o   = sel_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = dat_q;
    assign wbs_ack_o = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign wbs_dat_o = (state_q == ST_RESP) ? rdata_q :
                       (state_q == ST_ERR)  ? ERR_DATA : 32'h0;
    assign err_irq_o = (state_q == ST_ERR);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_slave_splitter.sv
// ---------------------------------------------------------------------------
// tb_wb_slave_splitter
//
// Self-checking bench for wb_slave_splitter (4 slaves, default windows,
// TIMEOUT_CYCLES=8). A table of directed transactions is replayed by
// applyStimulus; hand-written sequences cover abort, timeout (only when
// WB_SPLITTER_TIMEOUT_EN is defined), error-count saturation, reset during
// ACTIVE and back-to-back reads. Inputs change and outputs are sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_slave_splitter;

    localparam int          N_SLAVES = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_C0DE;

    logic                  wb_clk_i;
    logic                  wb_rst_i;
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic [N_SLAVES-1:0]   m_cyc_o;
    logic [N_SLAVES-1:0]   m_stb_o;
    logic                  m_we_o;
    logic [3:0]            m_sel_o;
    logic [15:0]           m_adr_o;
    logic [31:0]           m_dat_o;
    logic [N_SLAVES*32-1:0] m_dat_i;
    logic [N_SLAVES-1:0]   m_ack_i;
    logic                  err_irq_o;
    logic [7:0]            err_cnt_o;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_err_cnt = 8'h00;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_stb;
        logic [15:0] exp_adr;
        logic [31:0] exp_rdat;
        logic        exp_err;
        logic        keep;
    } vec_t;

    vec_t vecs[10];
    vec_t b2b[3];

    wb_slave_splitter #(
        .N_SLAVES        (N_SLAVES),
        .ADDR_BASE       (32'h3000_0000),
        .SLAVE_ADDR_BITS (16),
        .TIMEOUT_CYCLES  (8),
        .ERR_DATA        (ERR_DATA)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .err_irq_o (err_irq_o),
        .err_cnt_o (err_cnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Hard stop in case the run ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},     32'(wbs_ack_o), 32'h0);
        checkOutput({tag, "_rdat"},    wbs_dat_o,      32'h0);
        checkOutput({tag, "_cyc"},     32'(m_cyc_o),   32'h0);
        checkOutput({tag, "_stb"},     32'(m_stb_o),   32'h0);
        checkOutput({tag, "_we"},      32'(m_we_o),    32'h0);
        checkOutput({tag, "_sel"},     32'(m_sel_o),   32'h0);
        checkOutput({tag, "_adr"},     32'(m_adr_o),   32'h0);
        checkOutput({tag, "_mdat"},    m_dat_o,        32'h0);
        checkOutput({tag, "_irq"},     32'(err_irq_o), 32'h0);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt_o), 32'h0);
    endtask

    task automatic driveSlaveData(input logic [3:0] onehot, input logic [31:0] rdata);
        for (int k = 0; k < N_SLAVES; k++) begin
            m_dat_i[32*k +: 32] = onehot[k] ? rdata : (32'h0BAD_0000 | 32'(k));
        end
    endtask

    task automatic bumpErrCount();
        if (exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
    endtask

    // One complete upstream transaction; non-selected slaves ack during the
    // wait cycles to show they are ignored.
    task automatic applyStimulus(input vec_t v);
        @(negedge wb_clk_i);
        checkOutput("idle_stb", 32'(m_stb_o), 32'h0);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = v.we;
        wbs_sel_i = v.sel;
        wbs_adr_i = v.adr;
        wbs_dat_i = v.dat;
        m_ack_i   = '0;
        driveSlaveData(v.exp_stb, v.rdata);
        @(negedge wb_clk_i);
        if (v.exp_err) begin
            checkOutput("err_stb",  32'(m_stb_o),   32'h0);
            checkOutput("err_ack",  32'(wbs_ack_o), 32'h1);
            checkOutput("err_rdat", wbs_dat_o,      ERR_DATA);
            checkOutput("err_irq",  32'(err_irq_o), 32'h1);
            bumpErrCount();
        end else begin
            checkOutput("req_stb",  32'(m_stb_o),   32'(v.exp_stb));
            checkOutput("req_cyc",  32'(m_cyc_o),   32'(v.exp_stb));
            checkOutput("req_adr",  32'(m_adr_o),   32'(v.exp_adr));
            checkOutput("req_we",   32'(m_we_o),    32'(v.we));
            checkOutput("req_sel",  32'(m_sel_o),   32'(v.sel));
            checkOutput("req_mdat", m_dat_o,        v.dat);
            checkOutput("req_ack",  32'(wbs_ack_o), 32'h0);
            for (int i = 0; i < v.delay; i++) begin
                m_ack_i = ~v.exp_stb;
                @(negedge wb_clk_i);
                checkOutput("wait_ack", 32'(wbs_ack_o), 32'h0);
                checkOutput("wait_stb", 32'(m_stb_o),   32'(v.exp_stb));
            end
            m_ack_i = v.exp_stb;
            @(negedge wb_clk_i);
            m_ack_i = '0;
            checkOutput("rsp_ack",  32'(wbs_ack_o), 32'h1);
            checkOutput("rsp_rdat", wbs_dat_o,      v.exp_rdat);
            checkOutput("rsp_stb",  32'(m_stb_o),   32'h0);
            checkOutput("rsp_irq",  32'(err_irq_o), 32'h0);
        end
        if (!v.keep) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
            @(negedge wb_clk_i);
            checkOutput("post_ack",     32'(wbs_ack_o), 32'h0);
            checkOutput("post_rdat",    wbs_dat_o,      32'h0);
            checkOutput("post_err_cnt", 32'(err_cnt_o), 32'(exp_err_cnt));
        end
    endtask

    initial begin
        vecs[0] = '{32'h3001_0010, 1'b0, 4'hF,    32'h0000_0000, 2, 32'h1234_5678, 4'b0010, 16'h0010, 32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{32'h3003_FFFC, 1'b1, 4'b0101, 32'hCAFE_F00D, 0, 32'h5555_AAAA, 4'b1000, 16'hFFFC, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2] = '{32'h3004_0000, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h0,         4'b0000, 16'h0000, ERR_DATA,      1'b1, 1'b0};
        vecs[3] = '{32'h3000_0000, 1'b0, 4'hF,    32'h1111_2222, 1, 32'h0000_0001, 4'b0001, 16'h0000, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4] = '{32'h2FFF_FFFC, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h0,         4'b0000, 16'h0000, ERR_DATA,      1'b1, 1'b0};
        vecs[5] = '{32'h3002_ABCD, 1'b0, 4'b0010, 32'h0000_0000, 7, 32'h7777_1111, 4'b0100, 16'hABCD, 32'h7777_1111, 1'b0, 1'b0};
        vecs[6] = '{32'h3000_0004, 1'b1, 4'b1000, 32'h0123_4567, 3, 32'h9999_9999, 4'b0001, 16'h0004, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'h3003_8000, 1'b0, 4'hF,    32'h0000_0000, 0, 32'h89AB_CDEF, 4'b1000, 16'h8000, 32'h89AB_CDEF, 1'b0, 1'b1};
        vecs[8] = '{32'h3001_FFFF, 1'b0, 4'b0001, 32'h0000_0000, 1, 32'h0F0F_0F0F, 4'b0010, 16'hFFFF, 32'h0F0F_0F0F, 1'b0, 1'b0};
        vecs[9] = '{32'hFFFF_FFFC, 1'b1, 4'hF,    32'hAAAA_5555, 0, 32'h0,         4'b0000, 16'h0000, ERR_DATA,      1'b1, 1'b0};

        b2b[0] = '{32'h3000_0100, 1'b0, 4'hF, 32'h0, 1, 32'hA0A0_0001, 4'b0001, 16'h0100, 32'hA0A0_0001, 1'b0, 1'b1};
        b2b[1] = '{32'h3003_0200, 1'b0, 4'hF, 32'h0, 0, 32'hB3B3_0002, 4'b1000, 16'h0200, 32'hB3B3_0002, 1'b0, 1'b1};
        b2b[2] = '{32'h3000_0300, 1'b0, 4'hF, 32'h0, 2, 32'hC0C0_0003, 4'b0001, 16'h0300, 32'hC0C0_0003, 1'b0, 1'b0};

        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        m_ack_i   = '0;
        m_dat_i   = '0;

        repeat (3) @(negedge wb_clk_i);
        checkAllZero("reset");
        wb_rst_i = 1'b0;

        $display("[TB] directed transaction table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] abort in third ACTIVE cycle with simultaneous slave ack");
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3001_0020;
        driveSlaveData(4'b0010, 32'h5A5A_5A5A);
        @(negedge wb_clk_i);
        checkOutput("abort_stb1", 32'(m_stb_o), 32'h2);
        @(negedge wb_clk_i);
        checkOutput("abort_stb2", 32'(m_stb_o), 32'h2);
        @(negedge wb_clk_i);
        checkOutput("abort_stb3", 32'(m_stb_o), 32'h2);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_ack_i   = 4'b0010;
        @(negedge wb_clk_i);
        m_ack_i = '0;
        checkOutput("abort_cyc",  32'(m_cyc_o),   32'h0);
        checkOutput("abort_ack",  32'(wbs_ack_o), 32'h0);
        @(negedge wb_clk_i);
        checkOutput("abort_ack2", 32'(wbs_ack_o), 32'h0);
        applyStimulus('{32'h3001_0024, 1'b0, 4'hF, 32'h0, 0, 32'h600D_0001, 4'b0010, 16'h0024, 32'h600D_0001, 1'b0, 1'b0});

`ifdef WB_SPLITTER_TIMEOUT_EN
        $display("[TB] slave 2 never acks, watchdog terminates");
        for (int t = 0; t < 300; t++) begin
            @(negedge wb_clk_i);
            wbs_cyc_i = 1'b1;
            wbs_stb_i = 1'b1;
            wbs_we_i  = 1'b0;
            wbs_sel_i = 4'hF;
            wbs_adr_i = 32'h3002_0040;
            m_ack_i   = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge wb_clk_i);
                checkOutput("to_stb", 32'(m_stb_o),   32'h4);
                checkOutput("to_ack", 32'(wbs_ack_o), 32'h0);
            end
            @(negedge wb_clk_i);
            checkOutput("to_end_stb", 32'(m_stb_o),   32'h0);
            checkOutput("to_end_ack", 32'(wbs_ack_o), 32'h1);
            checkOutput("to_rdat",    wbs_dat_o,      ERR_DATA);
            checkOutput("to_irq",     32'(err_irq_o), 32'h1);
            bumpErrCount();
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
            @(negedge wb_clk_i);
            checkOutput("to_err_cnt", 32'(err_cnt_o), 32'(exp_err_cnt));
        end
`endif

        $display("[TB] out-of-range error count saturation");
        for (int i = 0; i < 300; i++) begin
            logic [31:0] bad_adr;
            case (i % 3)
                0:       bad_adr = 32'h3004_0000;
                1:       bad_adr = 32'h2FFF_FFFC;
                default: bad_adr = 32'hFFFF_FFFC;
            endcase
            applyStimulus('{bad_adr, 1'b0, 4'hF, 32'h0, 0, 32'h0, 4'b0000, 16'h0000, ERR_DATA, 1'b1, 1'b0});
        end
        checkOutput("err_cnt_sat", 32'(err_cnt_o), 32'h0000_00FF);

        $display("[TB] reset during ACTIVE, then back-to-back reads");
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3002_0008;
        wbs_dat_i = 32'h1357_9BDF;
        m_ack_i   = '0;
        @(negedge wb_clk_i);
        checkOutput("rst_pre_stb", 32'(m_stb_o), 32'h4);
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checkAllZero("mid_reset");
        wb_rst_i    = 1'b0;
        exp_err_cnt = 8'h00;
        @(negedge wb_clk_i);
        checkOutput("rst_post_ack", 32'(wbs_ack_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(b2b[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
